hazard_stall_unit: RTL and testbench

- Pipeline hazard control for the 5-stage core (F/D/E/M/W). It is the stall/flush counterpart to the forwarding unit, and covers the hazards that forwarding cannot resolve.
- Handles four cases: load-use, taken branch, PC-write, and multi-cycle data-memory wait.
- Drives stall enables into the F/D/E/M pipeline registers and flush (bubble) controls into the D/E registers.
- Contains an FSM for multi-cycle stalls plus a memory-timeout watchdog.

---
 rtl/hazard_stall_unit.sv | 177 +++++++++++++++++
 tb/tb_hazard_stall_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: stall/flush control for the F/D/E/M/W pipeline.
// Covers the hazards forwarding cannot hide: load-use, taken branch,
// PC-writing instructions (fetch drain) and multi-cycle data-memory waits,
// plus a sticky watchdog for a data memory that never answers.
// Optional build macro: HAZARD_PERF_CNT_EN enables the stall_F cycle counter
// on stall_count; without it stall_count is tied to zero.
module hazard_stall_unit #(
  parameter int REG_W       = 4,
  parameter int PC_DRAIN    = 3,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] RegA_D,
  input  logic [REG_W-1:0] RegB_D,
  input  logic [REG_W-1:0] Rd_E,
  input  logic             memtoreg_E,
  input  logic             regw_e,
  input  logic             pcwrite_D,
  input  logic             branch_taken_E,
  input  logic             memreq_M,
  input  logic             mem_ready,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             mem_error,
  output logic [15:0]      stall_count
);

  localparam int              DRAIN_W    = (PC_DRAIN < 2) ? 1 : $clog2(PC_DRAIN + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(PC_DRAIN);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [7:0]      TMO_MAX    = 8'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_PC_WAIT  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic [DRAIN_W-1:0]   drain_nxt;
  logic [7:0]           tmo_cnt;
  logic                 err_flag;
  logic [15:0]          perf_cnt;

  logic                 frozen;
  logic                 load_use;
  logic                 pc_mode;

  // Watchdog counter increment, pinned at the timeout value so it never wraps.
  function automatic logic [7:0] tmo_inc(input logic [7:0] x);
    if (x >= TMO_MAX) begin
      return TMO_MAX;
    end
    return x + 8'd1;
  endfunction

  // Hazard detection shared by next-state and output logic.
  assign frozen   = memreq_M & ~mem_ready;
  assign load_use = memtoreg_E & regw_e & ((Rd_E == RegA_D) | (Rd_E == RegB_D));
  // Leaving MEM_WAIT with drain cycles outstanding resumes the PC drain in
  // the very cycle memory answers, so fetch is never released early.
  assign pc_mode  = (state == S_PC_WAIT) | ((state == S_MEM_WAIT) & (drain_cnt != '0));

  // State register and drain counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  // Next-state: a memory freeze pre-empts everything and holds the drain count.
  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    if (frozen) begin
      state_nxt = S_MEM_WAIT;
    end else if (pc_mode) begin
      if (drain_cnt == '0 || drain_cnt == DRAIN_ONE) begin
        drain_nxt = '0;
        state_nxt = S_RUN;
      end else begin
        drain_nxt = drain_cnt - DRAIN_ONE;
        state_nxt = S_PC_WAIT;
      end
    end else begin
      // RUN, or a MEM_WAIT exit with nothing left to drain, behaves as RUN.
      state_nxt = S_RUN;
      // A squashed (branch) or stalled (load-use) PC write must not start a drain.
      if (!branch_taken_E && !load_use && pcwrite_D) begin
        state_nxt = S_PC_WAIT;
        drain_nxt = DRAIN_INIT;
      end
    end
  end

  // Output decode; everything is held low while reset is asserted.
  always_comb begin
    stall_F     = 1'b0;
    stall_D     = 1'b0;
    stall_E     = 1'b0;
    stall_M     = 1'b0;
    flush_D     = 1'b0;
    flush_E     = 1'b0;
    mem_error   = 1'b0;
    stall_count = '0;
    if (rst) begin
      mem_error   = err_flag;
      stall_count = perf_cnt;
      if (frozen) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
      end else if (pc_mode) begin
        stall_F = 1'b1;
        flush_D = 1'b1;
        flush_E = branch_taken_E;
      end else if (branch_taken_E) begin
        // The D instruction is squashed, so a coincident load-use is moot.
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (load_use) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  // Memory watchdog: counts consecutive frozen cycles, latches a sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (frozen) begin
      tmo_cnt <= tmo_inc(tmo_cnt);
      if (tmo_inc(tmo_cnt) == TMO_MAX) begin
        err_flag <= 1'b1;
      end
    end else begin
      tmo_cnt <= '0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating 16-bit increment for the performance counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] x);
    if (x == 16'hFFFF) begin
      return x;
    end
    return x + 16'd1;
  endfunction

  // Performance counter: one tick per cycle with fetch stalled, any cause.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cnt <= '0;
    end else if (stall_F) begin
      perf_cnt <= sat_inc16(perf_cnt);
    end
  end
`else
  assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: each cycle the expected flags and
// stall_count are queued when inputs are driven and checked mid-cycle.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] RegA_D, RegB_D, Rd_E;
  logic       memtoreg_E, regw_e, pcwrite_D, branch_taken_E, memreq_M, mem_ready;
  logic       stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, mem_error;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  hazard_stall_unit #(.REG_W(4), .PC_DRAIN(3), .MEM_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .RegA_D(RegA_D), .RegB_D(RegB_D), .Rd_E(Rd_E),
    .memtoreg_E(memtoreg_E), .regw_e(regw_e), .pcwrite_D(pcwrite_D),
    .branch_taken_E(branch_taken_E), .memreq_M(memreq_M), .mem_ready(mem_ready),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .mem_error(mem_error),
    .stall_count(stall_count)
  );

  // Flag order: {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, mem_error}
  localparam logic [6:0] NONE   = 7'b0000000;
  localparam logic [6:0] LU     = 7'b1100010;
  localparam logic [6:0] BR     = 7'b0000110;
  localparam logic [6:0] PCW    = 7'b1000100;
  localparam logic [6:0] PCW_BR = 7'b1000110;
  localparam logic [6:0] FRZ    = 7'b1111000;
  localparam logic [6:0] ERR    = 7'b0000001;
`ifdef HAZARD_PERF_CNT_EN
  localparam logic [15:0] PERF_EXP = 16'd4;
`else
  localparam logic [15:0] PERF_EXP = 16'd0;
`endif

  typedef struct packed {
    logic [6:0]  flags;
    logic [15:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   tests   = 0;
  int   fails   = 0;
  int   exp_cnt = 0;

  function automatic logic [6:0] obs_flags();
    return {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, mem_error};
  endfunction

  task automatic push_exp(input logic [6:0] f);
    exp_t e;
    e.flags = f;
    e.cnt   = 16'(exp_cnt);
    sbq.push_back(e);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    e = sbq.pop_front();
    tests++;
    assert (obs_flags() === e.flags)
      else begin fails++; $error("FAIL %s flags got %b want %b", tag, obs_flags(), e.flags); end
    tests++;
    assert (stall_count === e.cnt)
      else begin fails++; $error("FAIL %s stall_count got %0d want %0d", tag, stall_count, e.cnt); end
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic cyc(input logic [6:0] f, input string tag);
    push_exp(f);
    @(negedge clk);
    compare(tag);
`ifdef HAZARD_PERF_CNT_EN
    if (f[6]) exp_cnt++;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegA_D = 4'h0; RegB_D = 4'h0; Rd_E = 4'h0;
    memtoreg_E = 1'b0; regw_e = 1'b0; pcwrite_D = 1'b0;
    branch_taken_E = 1'b0; memreq_M = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic load_in_e(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd);
    RegA_D = ra; RegB_D = rb; Rd_E = rd;
    memtoreg_E = 1'b1; regw_e = 1'b1;
  endtask

  initial begin
    // Reset asserted with hazard inputs active: outputs must stay low.
    idle();
    memreq_M = 1'b1; mem_ready = 1'b0; branch_taken_E = 1'b1;
    @(posedge clk); #1;
    cyc(NONE, "reset_gate");
    idle(); rst = 1'b1;
    cyc(NONE, "idle");

    // Load-use on source B, then load gone.
    load_in_e(4'h0, 4'h3, 4'h3); cyc(LU, "loaduse_b");
    idle();                      cyc(NONE, "loaduse_done");
    load_in_e(4'h0, 4'h4, 4'h3); cyc(NONE, "loaduse_nomatch");
    load_in_e(4'hF, 4'h1, 4'hF); cyc(LU, "loaduse_a_r15");
    load_in_e(4'h5, 4'h5, 4'h5); regw_e = 1'b0; cyc(NONE, "load_no_regw");
    idle();                      cyc(NONE, "idle2");

    // Branch beats load-use; a branch also squashes a PC write.
    load_in_e(4'h0, 4'h3, 4'h3); branch_taken_E = 1'b1; cyc(BR, "branch_loaduse");
    idle(); branch_taken_E = 1'b1; pcwrite_D = 1'b1;     cyc(BR, "branch_pcwrite");
    idle();                                              cyc(NONE, "after_branch");

    // PC write stalled by load-use does not start a drain.
    load_in_e(4'h0, 4'h3, 4'h3); pcwrite_D = 1'b1; cyc(LU, "pcw_blocked");
    idle();                                        cyc(NONE, "pcw_blocked_next");

    // Plain PC write: three drain cycles.
    pcwrite_D = 1'b1; cyc(NONE, "pcw_issue");
    idle();
    cyc(PCW, "drain1");
    cyc(PCW, "drain2");
    cyc(PCW, "drain3");
    cyc(NONE, "drain_done");

    // PC write with a memory freeze mid-drain; branch in last drain cycle.
    pcwrite_D = 1'b1; cyc(NONE, "pcw2_issue");
    idle();
    cyc(PCW, "drain2_1");
    memreq_M = 1'b1; mem_ready = 1'b0;
    cyc(FRZ, "drain_frz1");
    cyc(FRZ, "drain_frz2");
    mem_ready = 1'b1;
    cyc(PCW, "drain2_2_exit");
    idle(); branch_taken_E = 1'b1;
    cyc(PCW_BR, "drain2_3_branch");
    idle();
    cyc(NONE, "drain2_done");

    // Memory wait from RUN: five frozen cycles, branch ignored while frozen.
    memreq_M = 1'b1; mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      branch_taken_E = (k == 2);
      cyc(FRZ, "memwait");
    end
    branch_taken_E = 1'b0; mem_ready = 1'b1;
    cyc(NONE, "memwait_exit");
    idle();
    cyc(NONE, "memwait_idle");

    // Timeout: error visible once 255 frozen cycles have elapsed.
    memreq_M = 1'b1; mem_ready = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      cyc((k == 256) ? (FRZ | ERR) : FRZ, "timeout");
    end
    mem_ready = 1'b1;
    cyc(ERR, "err_sticky_exit");
    idle();
    cyc(ERR, "err_sticky_idle");

    // Async reset mid-freeze: outputs drop without a clock edge.
    memreq_M = 1'b1; mem_ready = 1'b0;
    cyc(FRZ | ERR, "refreeze");
    exp_cnt = 0;
    push_exp(NONE);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    compare("async_rst");
    @(posedge clk); #1;
    idle(); rst = 1'b1;
    cyc(NONE, "after_rst");

    // Performance count: one load-use plus a three-cycle drain.
    load_in_e(4'h3, 4'h0, 4'h3); cyc(LU, "perf_lu");
    idle();                      cyc(NONE, "perf_gap");
    pcwrite_D = 1'b1;            cyc(NONE, "perf_pcw");
    idle();
    cyc(PCW, "perf_d1");
    cyc(PCW, "perf_d2");
    cyc(PCW, "perf_d3");
    cyc(NONE, "perf_end");
    @(negedge clk);
    tests++;
    assert (stall_count === PERF_EXP)
      else begin fails++; $error("FAIL perf_total got %0d want %0d", stall_count, PERF_EXP); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
